// File: rtl/con4_pkg.sv
// Shared types for the Connect-4 board writer: board geometry, cell colours, FSM states.
package con4_pkg;

  localparam int ROWS = 6;
  localparam int COLS = 7;

  typedef enum logic [1:0] {
    EMPTY  = 2'b00,
    RED    = 2'b01,
    YELLOW = 2'b10
  } cell_t;

  // Row 0 is the top of the board, row ROWS-1 the bottom.
  typedef cell_t [0:ROWS-1][0:COLS-1] board_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_WRITE
  } state_t;

endpackage

// File: rtl/con4_board_writer_if.sv
// Drop-request handshake, frame pulse and board/status outputs between game logic, VGA path and writer.
interface con4_board_writer_if;
  import con4_pkg::*;

  logic              drop_valid;
  logic [2:0]        drop_col;
  logic [1:0]        drop_player;
  logic              drop_ready;
  logic              clear;
  logic              frame_start;
  logic              done;
  logic              rejected;
  logic [2:0]        landed_row;
  logic [COLS-1:0]   col_full;
  logic              board_full;
  board_t            board;

  modport master (
    output drop_valid, drop_col, drop_player, clear, frame_start,
    input  drop_ready, done, rejected, landed_row, col_full, board_full, board
  );

  modport slave (
    input  drop_valid, drop_col, drop_player, clear, frame_start,
    output drop_ready, done, rejected, landed_row, col_full, board_full, board
  );

endinterface

// File: rtl/con4_board_writer.sv
// Connect-4 board owner: drops pieces into a shadow board and commits it to the
// displayed board only on frame_start, so a frame never shows a half-updated board.
//
// state    | meaning
// ST_IDLE  | waiting for a drop request
// ST_SCAN  | walking the latched column bottom-up for the first empty cell
// ST_WRITE | placing the piece at row_q in the shadow board
module con4_board_writer
  import con4_pkg::*;
(
  input logic               clk,
  input logic               rst,
  con4_board_writer_if.slave bus
);

  localparam logic [2:0] COL_MAX = 3'(COLS - 1);
  localparam logic [2:0] ROW_BOT = 3'(ROWS - 1);

  state_t          state_q;
  logic [2:0]      row_q;
  logic [2:0]      col_q;
  cell_t           player_q;
  board_t          shadow_q;
  board_t          board_q;
  logic            dirty_q;
  logic            done_q;
  logic            rejected_q;
  logic [2:0]      landed_row_q;

  logic            req_bad_d;
  cell_t           scan_cell_d;
  logic [COLS-1:0] col_full_d;

  always_comb begin
    req_bad_d   = (bus.drop_col > COL_MAX) || (bus.drop_player == 2'b00) ||
                  (bus.drop_player == 2'b11);
    scan_cell_d = shadow_q[row_q][col_q];
    col_full_d  = '0;
    for (int c = 0; c < COLS; c++) begin
      col_full_d[c] = (shadow_q[0][c] != EMPTY);
    end
  end

  assign bus.drop_ready = (state_q == ST_IDLE) & ~bus.clear & ~rst;
  assign bus.done       = done_q;
  assign bus.rejected   = rejected_q;
  assign bus.landed_row = landed_row_q;
  assign bus.col_full   = col_full_d;
  assign bus.board_full = &col_full_d;
  assign bus.board      = board_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      row_q        <= '0;
      col_q        <= '0;
      player_q     <= EMPTY;
      shadow_q     <= '{default: EMPTY};
      board_q      <= '{default: EMPTY};
      dirty_q      <= 1'b0;
      done_q       <= 1'b0;
      rejected_q   <= 1'b0;
      landed_row_q <= '0;
    end else begin
      done_q     <= 1'b0;
      rejected_q <= 1'b0;

      // Commit takes the shadow as it was before this edge; a write or clear
      // on the same edge re-sets dirty below so it lands on the next frame.
      if (bus.frame_start && dirty_q) begin
        board_q <= shadow_q;
        dirty_q <= 1'b0;
      end

      if (bus.clear) begin
        shadow_q <= '{default: EMPTY};
        dirty_q  <= 1'b1;
        state_q  <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (bus.drop_valid) begin
              if (req_bad_d) begin
                rejected_q <= 1'b1;
              end else begin
                col_q    <= bus.drop_col;
                player_q <= cell_t'(bus.drop_player);
                row_q    <= ROW_BOT;
                state_q  <= ST_SCAN;
              end
            end
          end
          ST_SCAN: begin
            if (scan_cell_d == EMPTY) begin
              state_q <= ST_WRITE;
            end else if (row_q != 3'd0) begin
              row_q <= row_q - 3'd1;
            end else begin
              rejected_q <= 1'b1;
              state_q    <= ST_IDLE;
            end
          end
          ST_WRITE: begin
            shadow_q[row_q][col_q] <= player_q;
            dirty_q                <= 1'b1;
            landed_row_q           <= row_q;
            done_q                 <= 1'b1;
            state_q                <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_con4_board_writer.sv
// Directed checks of drop latency, landing rows, rejection, frame commit, clear and reset.
module tb_con4_board_writer;
  import con4_pkg::*;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;
  board_t exp_b;

  con4_board_writer_if bus ();

  con4_board_writer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Drive a request for one cycle, then wait (bounded) for done or rejected.
  // kind: 1 = done, 2 = rejected, 0 = nothing seen; lat counts cycles after the accept edge.
  task automatic do_drop(input int col, input int pl, output int lat, output int kind,
                         output int lrow);
    bus.drop_valid  = 1'b1;
    bus.drop_col    = col[2:0];
    bus.drop_player = pl[1:0];
    @(posedge clk); #1;
    bus.drop_valid = 1'b0;
    lat = -1; kind = 0; lrow = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = k; kind = 1; lrow = int'(bus.landed_row);
        break;
      end
      if (bus.rejected) begin
        lat = k; kind = 2;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic frame();
    bus.frame_start = 1'b1;
    @(posedge clk); #1;
    bus.frame_start = 1'b0;
  endtask

  task automatic count_pulses(input int cycles, output int pulses);
    pulses = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (bus.done || bus.rejected) pulses++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, kind, lrow, pulses, pl;
    n_chk = 0; n_pass = 0;
    exp_b = '{default: EMPTY};
    rst = 1'b1;
    bus.drop_valid = 1'b0; bus.drop_col = '0; bus.drop_player = '0;
    bus.clear = 1'b0; bus.frame_start = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("ready_in_reset", 128'(bus.drop_ready), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 128'(bus.drop_ready), 128'(1));
    check("reset_flags", 128'({bus.done, bus.rejected, bus.board_full}), 128'(0));
    check("reset_landed", 128'(bus.landed_row), 128'(0));
    check("reset_col_full", 128'(bus.col_full), 128'(0));
    check("reset_board", 128'(bus.board), 128'(exp_b));
    @(posedge clk); #1;

    // Empty-column drop
    do_drop(0, 1, lat, kind, lrow);
    check("c0_kind", 128'(kind), 128'(1));
    check("c0_lat", 128'(lat), 128'(3));
    check("c0_row", 128'(lrow), 128'(5));
    check("c0_shadow", 128'(dut.shadow_q[5][0]), 128'(2'b01));
    check("c0_board_pre", 128'(bus.board[5][0]), 128'(2'b00));
    frame();
    exp_b[5][0] = RED;
    check("c0_board_post", 128'(bus.board), 128'(exp_b));

    // Fill column 3, then overflow it
    for (int i = 0; i < ROWS; i++) begin
      pl = (i % 2 == 0) ? 1 : 2;
      do_drop(3, pl, lat, kind, lrow);
      check("c3_kind", 128'(kind), 128'(1));
      check("c3_lat", 128'(lat), 128'(i + 3));
      check("c3_row", 128'(lrow), 128'(5 - i));
      exp_b[5 - i][3] = cell_t'(pl[1:0]);
    end
    check("c3_col_full", 128'(bus.col_full), 128'(7'b0001000));
    check("c3_board_full", 128'(bus.board_full), 128'(0));
    frame();
    check("c3_board", 128'(bus.board), 128'(exp_b));
    do_drop(3, 1, lat, kind, lrow);
    check("c3_over_kind", 128'(kind), 128'(2));
    check("c3_over_lat", 128'(lat), 128'(7));
    frame();
    check("c3_over_board", 128'(bus.board), 128'(exp_b));
    check("c3_over_shadow", 128'(dut.shadow_q), 128'(exp_b));

    // Bad requests
    do_drop(7, 1, lat, kind, lrow);
    check("bad_col", 128'({kind, lat}), 128'({32'd2, 32'd1}));
    do_drop(1, 0, lat, kind, lrow);
    check("bad_pl0", 128'({kind, lat}), 128'({32'd2, 32'd1}));
    do_drop(1, 3, lat, kind, lrow);
    check("bad_pl3", 128'({kind, lat}), 128'({32'd2, 32'd1}));
    check("bad_shadow", 128'(dut.shadow_q), 128'(exp_b));
    frame();
    check("bad_board", 128'(bus.board), 128'(exp_b));

    // Commit race: frame_start lands on the WRITE cycle
    bus.drop_valid = 1'b1; bus.drop_col = 3'd6; bus.drop_player = 2'b10;
    @(posedge clk); #1;
    bus.drop_valid = 1'b0;
    @(posedge clk); #1;
    bus.frame_start = 1'b1;
    @(posedge clk); #1;
    bus.frame_start = 1'b0;
    check("race_done", 128'({bus.done, bus.landed_row}), 128'({1'b1, 3'd5}));
    check("race_board_excl", 128'(bus.board), 128'(exp_b));
    check("race_dirty_kept", 128'(dut.dirty_q), 128'(1));
    frame();
    exp_b[5][6] = YELLOW;
    check("race_board_incl", 128'(bus.board), 128'(exp_b));
    check("race_dirty_clr", 128'(dut.dirty_q), 128'(0));

    // Clear during SCAN (column 0 holds one piece, so SCAN runs two cycles)
    bus.drop_valid = 1'b1; bus.drop_col = 3'd0; bus.drop_player = 2'b10;
    @(posedge clk); #1;
    bus.drop_valid = 1'b0;
    bus.clear = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0;
    count_pulses(10, pulses);
    check("clr_no_pulse", 128'(pulses), 128'(0));
    check("clr_shadow", 128'(dut.shadow_q), 128'(0));
    check("clr_col_full", 128'(bus.col_full), 128'(0));
    check("clr_board_held", 128'(bus.board), 128'(exp_b));
    frame();
    exp_b = '{default: EMPTY};
    check("clr_board", 128'(bus.board), 128'(exp_b));

    // Clear together with drop_valid: request must not be accepted
    bus.clear = 1'b1; bus.drop_valid = 1'b1; bus.drop_col = 3'd1; bus.drop_player = 2'b01;
    @(negedge clk);
    check("clr_ready", 128'(bus.drop_ready), 128'(0));
    @(posedge clk); #1;
    bus.clear = 1'b0; bus.drop_valid = 1'b0;
    count_pulses(10, pulses);
    check("clr_req_pulse", 128'(pulses), 128'(0));
    check("clr_req_shadow", 128'(dut.shadow_q), 128'(0));
    frame();

    // Fill the whole board
    for (int c = 0; c < COLS; c++) begin
      for (int i = 0; i < ROWS; i++) begin
        pl = ((c + i) % 2 == 0) ? 1 : 2;
        do_drop(c, pl, lat, kind, lrow);
        check("fill_done", 128'({kind, lat, lrow}), 128'({32'd1, 32'(i + 3), 32'(5 - i)}));
        exp_b[5 - i][c] = cell_t'(pl[1:0]);
      end
    end
    check("full_col_full", 128'(bus.col_full), 128'(7'h7f));
    check("full_board_full", 128'(bus.board_full), 128'(1));
    do_drop(2, 1, lat, kind, lrow);
    check("full_reject", 128'({kind, lat}), 128'({32'd2, 32'd7}));
    do_drop(6, 2, lat, kind, lrow);
    check("full_reject2", 128'({kind, lat}), 128'({32'd2, 32'd7}));
    frame();
    check("full_board", 128'(bus.board), 128'(exp_b));

    // Reset in the middle of SCAN
    bus.drop_valid = 1'b1; bus.drop_col = 3'd4; bus.drop_player = 2'b01;
    @(posedge clk); #1;
    bus.drop_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rst_ready_low", 128'(bus.drop_ready), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready_high", 128'(bus.drop_ready), 128'(1));
    check("rst_outs", 128'({bus.done, bus.rejected, bus.landed_row, bus.col_full, bus.board_full}),
          128'(0));
    check("rst_board", 128'(bus.board), 128'(0));
    @(posedge clk); #1;
    count_pulses(10, pulses);
    check("rst_no_pulse", 128'(pulses), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
